seg_scan_decoder: RTL and testbench

//   Receive-side counterpart of the multiplexed 8-digit seven-segment driver.

---
 rtl/seg_scan_decoder.sv | 187 ++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - seven-segment scan readback: settles each digit slot,
// decodes segments to hex and publishes complete 8-digit frames atomically.
module seg_scan_decoder #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 200000
) (
  input  logic        ck,
  input  logic        reset,
  input  logic [7:0]  an,
  input  logic [6:0]  seg,
  input  logic        dp,
  output logic [31:0] digits,
  output logic [7:0]  digit_ok,
  output logic [7:0]  dp_out,
  output logic        frame_done,
  output logic        scan_err,
  output logic        stale
);
  localparam int CW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_WAIT} state_t;

  state_t          state, state_nx;
  logic [7:0]      an_s1, an_s2;
  logic [6:0]      seg_s1, seg_s2;
  logic            dp_s1, dp_s2;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [2:0]      idx, idx_q, idx_nx;
  logic            legal, gap, ill, ill_q, cap, publish;
  logic [3:0]      dec_val;
  logic            dec_ok;
  logic [31:0]     shadow_val;
  logic [7:0]      shadow_ok, shadow_dp, seen, seen_nx;
  logic [TW-1:0]   tmo;

  always_comb begin
    gap   = &an_s2;
    legal = 1'b0;
    idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (an_s2 == ~(8'h01 << i)) begin
        legal = 1'b1;
        idx   = 3'(i);
      end
    end
    ill = !gap && !legal;
  end

  always_comb begin
    dec_ok = 1'b1;
    case (seg_s2)
      7'b0000001: dec_val = 4'h0;
      7'b1001111: dec_val = 4'h1;
      7'b0010010: dec_val = 4'h2;
      7'b0000110: dec_val = 4'h3;
      7'b1001100: dec_val = 4'h4;
      7'b0100100: dec_val = 4'h5;
      7'b0100000: dec_val = 4'h6;
      7'b0001111: dec_val = 4'h7;
      7'b0000000: dec_val = 4'h8;
      7'b0000100: dec_val = 4'h9;
      7'b0001000: dec_val = 4'hA;
      7'b1100000: dec_val = 4'hB;
      7'b0110001: dec_val = 4'hC;
      7'b1000010: dec_val = 4'hD;
      7'b0110000: dec_val = 4'hE;
      7'b0111000: dec_val = 4'hF;
      default: begin
        dec_val = 4'h0;
        dec_ok  = 1'b0;
      end
    endcase
  end

  // cnt counts cycles the current index has been stable, the first cycle included
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx_q;
    cap      = 1'b0;
    if (ill) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt_nx = '0;
          if (legal) begin
            state_nx = S_SETTLE;
            idx_nx   = idx;
            cnt_nx   = CW'(1);
          end
        end
        S_SETTLE: begin
          if (gap) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
          end else if (idx != idx_q) begin
            idx_nx = idx;
            cnt_nx = CW'(1);
          end else if (cnt >= CW'(SETTLE - 1)) begin
            state_nx = S_CAPTURE;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          cap      = legal && (idx == idx_q);
          state_nx = S_WAIT;
        end
        default: begin
          if (gap) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
          end else if (idx != idx_q) begin
            state_nx = S_SETTLE;
            idx_nx   = idx;
            cnt_nx   = CW'(1);
          end
        end
      endcase
    end
  end

  // Publishing empties the mask before a same-cycle capture marks its digit
  always_comb begin
    publish = (seen == 8'hFF) && !ill;
    seen_nx = publish ? 8'h00 : seen;
    if (cap) seen_nx[idx_q] = 1'b1;
    if (ill) seen_nx = 8'h00;
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx_q <= 3'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx_q <= idx_nx;
    end
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      an_s1 <= 8'hFF; an_s2 <= 8'hFF;
      seg_s1 <= '0;   seg_s2 <= '0;
      dp_s1 <= 1'b0;  dp_s2 <= 1'b0;
      ill_q      <= 1'b0;
      scan_err   <= 1'b0;
      frame_done <= 1'b0;
      digits     <= '0;
      digit_ok   <= '0;
      dp_out     <= '0;
      shadow_val <= '0;
      shadow_ok  <= '0;
      shadow_dp  <= '0;
      seen       <= '0;
      tmo        <= '0;
      stale      <= 1'b1;
    end else begin
      an_s1 <= an;   an_s2 <= an_s1;
      seg_s1 <= seg; seg_s2 <= seg_s1;
      dp_s1 <= dp;   dp_s2 <= dp_s1;
      ill_q      <= ill;
      scan_err   <= ill && !ill_q;
      frame_done <= publish;
      seen       <= seen_nx;
      if (publish) begin
        digits   <= shadow_val;
        digit_ok <= shadow_ok;
        dp_out   <= shadow_dp;
      end
      if (cap) begin
        shadow_val[{idx_q, 2'b00} +: 4] <= dec_val;
        shadow_ok[idx_q] <= dec_ok;
        shadow_dp[idx_q] <= ~dp_s2;
      end
      if (cap) tmo <= '0;
      else if (tmo != TW'(TIMEOUT)) tmo <= tmo + 1'b1;
      if (publish) stale <= 1'b0;
      else if (tmo == TW'(TIMEOUT)) stale <= 1'b1;
    end
  end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - scoreboard bench for seg_scan_decoder.
module tb_seg_scan_decoder;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 64;
  localparam int HOLD    = 16;

  logic        ck = 1'b0;
  logic        reset;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [31:0] digits;
  logic [7:0]  digit_ok, dp_out;
  logic        frame_done, scan_err, stale;

  always #5 ck = ~ck;

  seg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .ck(ck), .reset(reset), .an(an), .seg(seg), .dp(dp),
    .digits(digits), .digit_ok(digit_ok), .dp_out(dp_out),
    .frame_done(frame_done), .scan_err(scan_err), .stale(stale)
  );

  typedef struct {
    logic [31:0] d;
    logic [7:0]  ok;
    logic [7:0]  dpm;
  } frame_t;

  frame_t     exp_q[$];
  frame_t     mon_e;
  int         checks = 0, failures = 0, frames = 0, errs = 0;
  logic [6:0] seg_tab [16];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge ck);
    #1;
  endtask

  task automatic push_frame(input logic [31:0] d, input logic [7:0] ok, input logic [7:0] dpm);
    frame_t f;
    f.d = d; f.ok = ok; f.dpm = dpm;
    exp_q.push_back(f);
  endtask

  task automatic scan(input logic [31:0] vals, input logic [7:0] blank, input logic [7:0] dpm,
                      input int first, input int last);
    for (int i = first; i <= last; i++) begin
      an    = 8'hFF;
      an[i] = 1'b0;
      seg   = blank[i] ? 7'h7F : seg_tab[vals[4*i +: 4]];
      dp    = ~dpm[i];
      tick(HOLD);
    end
  endtask

  always @(negedge ck) begin
    if (scan_err) errs++;
    if (frame_done) begin
      frames++;
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("frame_digits", digits, mon_e.d);
        check_eq("frame_ok", {24'h0, digit_ok}, {24'h0, mon_e.ok});
        check_eq("frame_dp", {24'h0, dp_out}, {24'h0, mon_e.dpm});
        check_eq("frame_stale", {31'h0, stale}, 32'h0);
      end
    end
  end

  initial begin
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    reset = 1'b0; an = 8'hFF; seg = 7'h7F; dp = 1'b1;
    tick(3);
    check_eq("rst_digits", digits, 32'h0);
    check_eq("rst_ok", {24'h0, digit_ok}, 32'h0);
    check_eq("rst_stale", {31'h0, stale}, 32'h1);
    reset = 1'b1;
    tick(3);

    // clean scan, values 1..8
    push_frame(32'h87654321, 8'hFF, 8'h00);
    scan(32'h87654321, 8'h00, 8'h00, 0, 7);
    an = 8'hFF; tick(4);
    check_eq("t1_frames", frames, 1);

    // blank digit 3, dp on digit 5
    push_frame(32'h87650321, 8'hF7, 8'h20);
    scan(32'h87654321, 8'h08, 8'h20, 0, 7);
    an = 8'hFF; tick(4);
    check_eq("t2_frames", frames, 2);

    // illegal anode mid-frame
    scan(32'hCAFE1234, 8'h00, 8'h00, 0, 3);
    an = 8'b11110011; tick(10);
    check_eq("t3_err_once", errs, 1);
    an = 8'hFF; tick(4);
    check_eq("t3_noframe", frames, 2);
    push_frame(32'hCAFE1234, 8'hFF, 8'h00);
    scan(32'hCAFE1234, 8'h00, 8'h00, 0, 7);
    an = 8'hFF; tick(4);
    check_eq("t3_frames", frames, 3);
    check_eq("t3_err_total", errs, 1);

    // short glitch on digit 2; clean scan visits digit 2 last
    an = 8'hFF; an[2] = 1'b0; seg = seg_tab[4'hF]; dp = 1'b1;
    tick(2);
    an = 8'hFF; tick(6);
    push_frame(32'hFEDCBA90, 8'hFF, 8'h00);
    scan(32'hFEDCBA90, 8'h00, 8'h00, 0, 1);
    scan(32'hFEDCBA90, 8'h00, 8'h00, 3, 7);
    check_eq("t4_wait_digit2", frames, 3);
    scan(32'hFEDCBA90, 8'h00, 8'h00, 2, 2);
    an = 8'hFF; tick(4);
    check_eq("t4_frames", frames, 4);

    // timeout -> stale, cleared by next frame
    an = 8'hFF; tick(TIMEOUT + 5);
    check_eq("t5_stale", {31'h0, stale}, 32'h1);
    push_frame(32'h2468ACE0, 8'hFF, 8'h81);
    scan(32'h2468ACE0, 8'h00, 8'h81, 0, 7);
    an = 8'hFF; tick(4);
    check_eq("t5_frames", frames, 5);

    // reset mid-frame after 5 captures
    scan(32'h13579BDF, 8'h00, 8'h00, 0, 4);
    reset = 1'b0;
    #2;
    check_eq("t6_digits", digits, 32'h0);
    check_eq("t6_ok", {24'h0, digit_ok}, 32'h0);
    check_eq("t6_dp", {24'h0, dp_out}, 32'h0);
    check_eq("t6_pulses", {30'h0, frame_done, scan_err}, 32'h0);
    check_eq("t6_stale", {31'h0, stale}, 32'h1);
    tick(3);
    reset = 1'b1; an = 8'hFF;
    tick(2);
    scan(32'h13579BDF, 8'h00, 8'h00, 5, 7);
    an = 8'hFF; tick(4);
    check_eq("t6_noframe", frames, 5);
    push_frame(32'h13579BDF, 8'hFF, 8'h00);
    scan(32'h13579BDF, 8'h00, 8'h00, 0, 7);
    an = 8'hFF; tick(4);
    check_eq("t6_frames", frames, 6);
    check_eq("sb_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
